// File: rtl/timer_pkg.sv
// Shared constants, state encoding and BCD helpers
// for the M:SS countdown timer.
package timer_pkg;

  localparam int DIG_W = 4;

  localparam logic [DIG_W-1:0] SEC_T_MAX = 4'd5;
  localparam logic [DIG_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DONE  = 3'd3
  } state_e;

  typedef struct packed {
    logic [DIG_W-1:0] m;
    logic [DIG_W-1:0] t;
    logic [DIG_W-1:0] o;
  } bcd_t;

  function automatic bcd_t bcd_dec(input bcd_t v);
    bcd_t r;
    r = v;
    if (v.o != 4'd0) begin
      r.o = v.o - 4'd1;
    end else begin
      r.o = DIGIT_MAX;
      if (v.t != 4'd0) begin
        r.t = v.t - 4'd1;
      end else begin
        r.t = SEC_T_MAX;
        r.m = v.m - 4'd1;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input bcd_t v);
    return (v.m <= DIGIT_MAX) &&
           (v.t <= SEC_T_MAX) &&
           (v.o <= DIGIT_MAX) &&
           (v != '0);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV
// enabled cycles; the count holds while en is low.
module tick_prescaler #(
  parameter int TICK_DIV = 24000000,
  parameter int PRESC_W  = 25
) (
  input  logic clk,
  input  logic res,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST =
    PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // next count: clear, wrap on tick, or advance
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // prescaler count register
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// M:SS countdown FSM with BCD borrow decrement.
// Optional periodic reload: TIMER_AUTO_RELOAD_EN.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 24000000,
  parameter int PRESC_W  = 25
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [3:0] pre_min,
  input  logic [3:0] pre_sec_t,
  input  logic [3:0] pre_sec_o,
  output logic [3:0] min_num,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  state_e state_q, state_d;
  bcd_t   cnt_q, cnt_d;
  logic   run_q, run_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic   presc_clr;
  logic   tick;
  bcd_t   pre;
  bcd_t   nxt;

`ifdef TIMER_AUTO_RELOAD_EN
  bcd_t   rld_q, rld_d;
`endif

  assign pre = '{m: pre_min, t: pre_sec_t, o: pre_sec_o};
  assign nxt = bcd_dec(cnt_q);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRESC_W  (PRESC_W)
  ) u_presc (
    .clk  (clk),
    .res  (res),
    .en   (state_q == ST_RUN),
    .clr  (presc_clr),
    .tick (tick)
  );

  // command arbitration, next state and digit update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    presc_clr = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    rld_d     = rld_q;
`endif
    if (clear) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (bcd_ok(pre)) begin
              state_d   = ST_RUN;
              cnt_d     = pre;
              presc_clr = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
              rld_d     = pre;
`endif
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause && !start) state_d = ST_PAUSE;
          if (tick) begin
            cnt_d = nxt;
            if (nxt == '0) begin
              done_d = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
              cnt_d   = rld_q;
              state_d = ST_RUN;
`else
              state_d = ST_DONE;
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    run_d = (state_d == ST_RUN);
  end

  // state, digits and output pulse registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef TIMER_AUTO_RELOAD_EN
  // preset captured at the last accepted start
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rld_q <= '0;
    end else begin
      rld_q <= rld_d;
    end
  end
`endif

  assign min_num = cnt_q.m;
  assign sec_t   = cnt_q.t;
  assign sec_o   = cnt_q.o;
  assign running = run_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: a seconds-
// based reference model predicts every cycle's outputs.
module tb_countdown_timer_ctrl;

  localparam int TD = 4;
  localparam int PW = 3;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] pre_min = '0;
  logic [3:0] pre_sec_t = '0;
  logic [3:0] pre_sec_o = '0;
  logic [3:0] min_num, sec_t, sec_o;
  logic       running, done, err;
  logic [2:0] state;

  countdown_timer_ctrl #(
    .TICK_DIV (TD),
    .PRESC_W  (PW)
  ) dut (
    .clk       (clk),
    .res       (res),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .pre_min   (pre_min),
    .pre_sec_t (pre_sec_t),
    .pre_sec_o (pre_sec_o),
    .min_num   (min_num),
    .sec_t     (sec_t),
    .sec_o     (sec_o),
    .running   (running),
    .done      (done),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef logic [18:0] obs_t;

  obs_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   ncyc = 0;

  // model: state as spec number, time as total seconds
  int ms = 0;
  int secs = 0;
  int pc = 0;
  int rld = 0;
  int md = 0;
  int me = 0;

  function automatic obs_t pack_obs(
    int s, int sc, int d, int e);
    obs_t v;
    v[18:15] = 4'(sc / 60);
    v[14:11] = 4'((sc % 60) / 10);
    v[10:7]  = 4'(sc % 10);
    v[6]     = (s == 1);
    v[5]     = d[0];
    v[4]     = e[0];
    v[3:0]   = 4'(s);
    return v;
  endfunction

  task automatic model_step();
    int tk;
    int pv;
    bit ok;
    if (!res) begin
      ms = 0; secs = 0; pc = 0;
      md = 0; me = 0; rld = 0;
    end else begin
      md = 0; me = 0;
      tk = (ms == 1 && pc == TD - 1);
      if (ms == 1) pc = (pc + 1) % TD;
      pv = pre_min * 60 + pre_sec_t * 10 + pre_sec_o;
      ok = pre_min <= 9 && pre_sec_t <= 5 &&
           pre_sec_o <= 9 && pv != 0;
      if (clear) begin
        ms = 0; secs = 0; pc = 0;
      end else if (start && (ms == 0 || ms == 3)) begin
        if (ok) begin
          ms = 1; secs = pv; pc = 0; rld = pv;
        end else begin
          me = 1;
        end
      end else if (start && ms == 2) begin
        ms = 1;
      end else if (ms == 1) begin
        if (pause && !start) ms = 2;
        if (tk) begin
          secs = secs - 1;
          if (secs == 0) begin
            md = 1;
`ifdef TIMER_AUTO_RELOAD_EN
            secs = rld;
            ms = 1;
`else
            ms = 3;
`endif
          end
        end
      end
    end
    q.push_back(pack_obs(ms, secs, md, me));
  endtask

  task automatic cyc(input logic r, c, s, p,
                     input logic [3:0] m, t, o);
    @(negedge clk);
    res = r; clear = c; start = s; pause = p;
    pre_min = m; pre_sec_t = t; pre_sec_o = o;
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic reset_mid();
    obs_t g;
    @(negedge clk);
    clear = 0; start = 0; pause = 0;
    #2 res = 1'b0;
    #1;
    g = {min_num, sec_t, sec_o, running, done, err, 1'b0, state};
    n_chk++;
    if (g !== '0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=0", g);
    end
    @(posedge clk);
    model_step();
    cyc(1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
  endtask

  // monitor: compare DUT against the oldest prediction
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      ncyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        g = {min_num, sec_t, sec_o, running, done, err,
             1'b0, state};
        n_chk++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cycle%0d m:t:o/run/done/err/st got=%h want=%h",
                   ncyc, g, e);
        end
      end
    end
  end

  initial begin
    bit v;
    logic [3:0] m, t, o;
    cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    idle(2);
    // 0:03 runs down to DONE
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd3);
    idle(16);
    // borrow across seconds tens and minutes
    cyc(1, 0, 1, 0, 4'd1, 4'd0, 4'd0);
    idle(6);
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 1, 0, 4'd2, 4'd1, 4'd0);
    idle(4 * 11 + 2);
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 4'd0);
    // pause with held prescaler, then resume
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd5);
    idle(5);
    cyc(1, 0, 0, 1, 4'd0, 4'd0, 4'd0);
    idle(20);
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    idle(8);
    // clear beats start; bad and zero presets
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd9);
    idle(3);
    cyc(1, 1, 1, 0, 4'd0, 4'd1, 4'd0);
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd10);
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 1, 0, 4'd0, 4'd6, 4'd0);
    cyc(1, 0, 1, 0, 4'd10, 4'd0, 4'd1);
    idle(2);
    // tick and pause together
    cyc(1, 0, 1, 0, 4'd0, 4'd0, 4'd2);
    idle(3);
    cyc(1, 0, 0, 1, 4'd0, 4'd0, 4'd0);
    idle(3);
    // asynchronous reset mid-run
    cyc(1, 0, 1, 0, 4'd1, 4'd2, 4'd3);
    idle(9);
    reset_mid();
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) begin
        m = 4'($urandom_range(0, 1));
        t = 4'($urandom_range(0, 5));
        o = 4'($urandom_range(0, 9));
      end else begin
        m = 4'($urandom_range(0, 15));
        t = 4'($urandom_range(0, 15));
        o = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 999) < 2) begin
        reset_mid();
      end else begin
        cyc(1,
            $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 6,
            m, t, o);
      end
    end
    idle(2);
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
